// File: rtl/distribuidor_cartas_pkg.sv
// Shared definitions for the card server: deck size, card ceiling,
// FSM state encoding, LFSR taps and the fresh-deck value function.
package pacote_baralho;

   // Standard deck size
   localparam int NUM_CARTAS_PADRAO = 52;

   // Face cards (J, Q, K) count as 10, so no card is worth more than this
   localparam int CARTA_MAX = 10;

   // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register:
   // feedback is the XOR of bits 7, 5, 4 and 3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Deck server states
   typedef enum logic [2:0] {
      CARREGA   = 3'd0,
      ESCOLHE   = 3'd1,
      LE        = 3'd2,
      ESCREVE_I = 3'd3,
      ESCREVE_J = 3'd4,
      OCIOSO    = 3'd5
   } estado_t;

   // Value of card n in an unshuffled deck: ranks 1..13 repeat per suit,
   // and ranks above CARTA_MAX are clamped to CARTA_MAX
   function automatic logic [3:0] valor_inicial(input logic [5:0] n);
      logic [5:0] resto;
      resto = n % 6'd13;
      if (resto >= 6'(CARTA_MAX - 1)) begin
         valor_inicial = 4'(CARTA_MAX);
      end else begin
         valor_inicial = resto[3:0] + 4'd1;
      end
   endfunction

endpackage

// File: rtl/distribuidor_cartas_lfsr.sv
// 8-bit Fibonacci LFSR used as the shuffle entropy source.
// Loads the seed on reset and shifts left whenever enabled.
module lfsr_baralho
   import pacote_baralho::*;
#(
   parameter logic [7:0] SEMENTE = 8'hA5
) (
   input  logic       clock,
   input  logic       resetar,
   input  logic       habilita,
   output logic [7:0] estado
);

   logic [7:0] estado_q;
   logic [7:0] estado_d;
   logic       realimentacao;

   // Next LFSR value: shift left and insert the tap parity at bit 0
   always_comb begin
      realimentacao = ^(estado_q & LFSR_TAPS);
      estado_d      = estado_q;
      if (habilita) begin
         estado_d = {estado_q[6:0], realimentacao};
      end
   end

   // State register; reset reloads the (non-zero) seed
   always_ff @(posedge clock) begin
      if (resetar) begin
         estado_q <= SEMENTE;
      end else begin
         estado_q <= estado_d;
      end
   end

   assign estado = estado_q;

endmodule

// File: rtl/distribuidor_cartas.sv
// Shuffled-deck card server. Builds the deck in internal RAM, shuffles it
// with Fisher-Yates driven by an LFSR (rejection sampling for j <= i),
// then deals one card per request with a registered value and valid pulse.
module distribuidor_cartas
   import pacote_baralho::*;
#(
   parameter int         NUM_CARTAS = NUM_CARTAS_PADRAO,
   parameter logic [7:0] SEMENTE    = 8'hA5
) (
   input  logic       clock,
   input  logic       resetar,
   input  logic       embaralhar,
   input  logic       pedido,
   output logic [3:0] carta,
   output logic       carta_valida,
   output logic       pronto,
   output logic       baralho_vazio,
   output logic [5:0] cartas_restantes
);

   localparam logic [5:0] TOTAL         = 6'(NUM_CARTAS);
   localparam logic [5:0] TOTAL_MENOS_1 = 6'(NUM_CARTAS - 1);

   // FSM and datapath registers
   estado_t    estado_q, estado_d;
   logic [5:0] n_q, n_d;          // fill index while building the deck
   logic [5:0] i_q, i_d;          // Fisher-Yates upper index
   logic [5:0] j_q, j_d;          // accepted swap partner
   logic [5:0] topo_q, topo_d;    // next card to deal, saturates at TOTAL
   logic [3:0] carta_q;
   logic       valida_q;

   // Swap operands captured from RAM
   logic [3:0] tmp_i_q;
   logic [3:0] tmp_j_q;

   // RAM write port
   logic       mem_we;
   logic [5:0] mem_waddr;
   logic [3:0] mem_wdata;

   // Deal strobe for this cycle
   logic       entrega;

   // LFSR
   logic [7:0] lfsr;
   logic [5:0] j_cand;
   logic [1:0] lfsr_bits_unused;

   logic [3:0] mem [NUM_CARTAS];

   // Entropy source runs every cycle; reset reloads the seed
   lfsr_baralho #(
      .SEMENTE (SEMENTE)
   ) u_lfsr (
      .clock    (clock),
      .resetar  (resetar),
      .habilita (1'b1),
      .estado   (lfsr)
   );

   // Only the low six bits can address a 63-card deck
   assign j_cand           = lfsr[5:0];
   assign lfsr_bits_unused = lfsr[7:6];

   // State register plus datapath registers; the card register is a
   // registered RAM read taken only when a card is actually dealt
   always_ff @(posedge clock) begin
      if (resetar) begin
         estado_q <= CARREGA;
         n_q      <= '0;
         i_q      <= '0;
         j_q      <= '0;
         topo_q   <= '0;
         carta_q  <= '0;
         valida_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         n_q      <= n_d;
         i_q      <= i_d;
         j_q      <= j_d;
         topo_q   <= topo_d;
         valida_q <= entrega;
         if (entrega) begin
            carta_q <= mem[topo_q];
         end
      end
   end

   // Deck RAM: one write port, registered swap-operand reads in LE
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      if (estado_q == LE) begin
         tmp_i_q <= mem[i_q];
         tmp_j_q <= mem[j_q];
      end
   end

   // Next-state logic
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         CARREGA: begin
            if (n_q == TOTAL_MENOS_1) begin
               // A one-card deck has nothing to swap
               estado_d = (NUM_CARTAS == 1) ? OCIOSO : ESCOLHE;
            end
         end
         ESCOLHE: begin
            // Reject candidates above i so the pick stays in 0..i
            if (j_cand <= i_q) begin
               estado_d = LE;
            end
         end
         LE: begin
            estado_d = ESCREVE_I;
         end
         ESCREVE_I: begin
            estado_d = ESCREVE_J;
         end
         ESCREVE_J: begin
            estado_d = (i_q == 6'd1) ? OCIOSO : ESCOLHE;
         end
         OCIOSO: begin
            if (embaralhar) begin
               estado_d = CARREGA;
            end
         end
         default: begin
            estado_d = CARREGA;
         end
      endcase
   end

   // Datapath control: counters, RAM writes and card dealing per state
   always_comb begin
      n_d       = n_q;
      i_d       = i_q;
      j_d       = j_q;
      topo_d    = topo_q;
      mem_we    = 1'b0;
      mem_waddr = n_q;
      mem_wdata = valor_inicial(n_q);
      entrega   = 1'b0;
      case (estado_q)
         CARREGA: begin
            mem_we    = 1'b1;
            mem_waddr = n_q;
            mem_wdata = valor_inicial(n_q);
            n_d       = n_q + 6'd1;
            if (n_q == TOTAL_MENOS_1) begin
               n_d    = '0;
               i_d    = TOTAL_MENOS_1;
               topo_d = '0;
            end
         end
         ESCOLHE: begin
            if (j_cand <= i_q) begin
               j_d = j_cand;
            end
         end
         ESCREVE_I: begin
            mem_we    = 1'b1;
            mem_waddr = i_q;
            mem_wdata = tmp_j_q;
         end
         ESCREVE_J: begin
            mem_we    = 1'b1;
            mem_waddr = j_q;
            mem_wdata = tmp_i_q;
            i_d       = i_q - 6'd1;
            if (i_q == 6'd1) begin
               topo_d = '0;
            end
         end
         OCIOSO: begin
            // A reshuffle command takes priority over a same-cycle request
            if (embaralhar) begin
               n_d = '0;
            end else if (pedido && (topo_q != TOTAL)) begin
               entrega = 1'b1;
               topo_d  = topo_q + 6'd1;
            end
         end
         default: begin
            n_d = '0;
         end
      endcase
   end

   // Status outputs derived from the state and the deal pointer
   always_comb begin
      pronto           = (estado_q == OCIOSO);
      baralho_vazio    = pronto && (topo_q == TOTAL);
      cartas_restantes = pronto ? (TOTAL - topo_q) : 6'd0;
      carta            = carta_q;
      carta_valida     = valida_q;
   end

endmodule

// File: tb/tb_distribuidor_cartas.sv
// Bench for the card server: a deck/shuffle model predicts every output
// each cycle, plus directed scenarios with hand-computed expectations.
module tb_distribuidor_cartas;

   localparam int         N    = 52;
   localparam logic [7:0] SEED = 8'hA5;
   localparam int         LIMITE_ESPERA = 20000;

   logic       clock;
   logic       resetar;
   logic       embaralhar;
   logic       pedido;
   logic [3:0] carta;
   logic       carta_valida;
   logic       pronto;
   logic       baralho_vazio;
   logic [5:0] cartas_restantes;

   int errors = 0;
   int checks = 0;

   distribuidor_cartas #(
      .NUM_CARTAS (N),
      .SEMENTE    (SEED)
   ) dut (
      .clock            (clock),
      .resetar          (resetar),
      .embaralhar       (embaralhar),
      .pedido           (pedido),
      .carta            (carta),
      .carta_valida     (carta_valida),
      .pronto           (pronto),
      .baralho_vazio    (baralho_vazio),
      .cartas_restantes (cartas_restantes)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      checks++;
      if (atual !== esperado) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
      end
   endtask

   // ---------------- model ----------------
   function automatic logic [7:0] lfsr_prox(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   int m_deck [N];
   int m_cyc, m_ready, m_first_esc, m_topo, m_carta;
   bit m_pronto, m_valida, armed;
   logic s_res, s_emb, s_ped;

   // Fisher-Yates on a fresh deck; the CARREGA phase starts at cycle 'inicio'
   // (cycles counted from the reset edge, LFSR = seed stepped that many times)
   task automatic start_shuffle(input int inicio);
      logic [7:0] s;
      int t, j, tmp;
      for (int n = 0; n < N; n++) m_deck[n] = ((n % 13) + 1 > 10) ? 10 : (n % 13) + 1;
      s = SEED;
      for (int k = 0; k < inicio + N; k++) s = lfsr_prox(s);
      t = inicio + N;
      m_first_esc = -1;
      for (int i = N - 1; i >= 1; i--) begin
         do begin
            j = int'(s[5:0]);
            s = lfsr_prox(s);
            t++;
         end while (j > i);
         if (m_first_esc < 0) m_first_esc = t + 1;
         tmp = m_deck[i];
         m_deck[i] = m_deck[j];
         m_deck[j] = tmp;
         for (int k = 0; k < 3; k++) s = lfsr_prox(s);
         t += 3;
      end
      m_ready = t;
   endtask

   always @(posedge clock) begin
      s_res <= resetar;
      s_emb <= embaralhar;
      s_ped <= pedido;
   end

   // Model advance and per-cycle output comparison
   initial begin
      armed = 0;
      forever begin
         @(negedge clock);
         if (s_res === 1'b1) begin
            armed = 1; m_cyc = 0; m_pronto = 0; m_topo = 0; m_carta = 0; m_valida = 0;
            start_shuffle(0);
         end else if (armed) begin
            m_cyc++;
            m_valida = 0;
            if (m_pronto) begin
               if (s_emb) begin
                  m_pronto = 0;
                  start_shuffle(m_cyc);
               end else if (s_ped && m_topo < N) begin
                  m_carta = m_deck[m_topo];
                  m_valida = 1;
                  m_topo++;
               end
            end else if (m_cyc == m_ready) begin
               m_pronto = 1;
               m_topo = 0;
            end
         end
         if (armed) begin
            chk("cyc pronto", 32'(pronto), 32'(m_pronto));
            chk("cyc carta_valida", 32'(carta_valida), 32'(m_valida));
            chk("cyc carta", 32'(carta), 32'(m_carta));
            chk("cyc baralho_vazio", 32'(baralho_vazio), 32'(m_pronto && m_topo == N));
            chk("cyc cartas_restantes", 32'(cartas_restantes), 32'(m_pronto ? N - m_topo : 0));
         end
      end
   end

   // ---------------- stimulus ----------------
   int got[$];
   int seq1[$];
   int seq2[$];

   task automatic do_reset;
      resetar = 1'b1;
      @(negedge clock);
      resetar = 1'b0;
   endtask

   task automatic wait_pronto(input string nome);
      int k;
      k = 0;
      while (pronto !== 1'b1 && k < LIMITE_ESPERA) begin
         @(negedge clock);
         k++;
      end
      chk({nome, " pronto timeout"}, 32'(pronto), 32'd1);
   endtask

   task automatic pede_uma;
      pedido = 1'b1;
      @(negedge clock);
      pedido = 1'b0;
      chk("single pulse", 32'(carta_valida), 32'd1);
      got.push_back(int'(carta));
      $display("deal %0d: carta=%0d restantes=%0d", got.size(), carta, cartas_restantes);
      @(negedge clock);
   endtask

   task automatic check_multiset(input string nome);
      int cnt [11];
      int soma;
      soma = 0;
      for (int v = 0; v < 11; v++) cnt[v] = 0;
      foreach (got[k]) begin
         soma += got[k];
         if (got[k] >= 1 && got[k] <= 10) cnt[got[k]]++;
      end
      chk({nome, " count"}, 32'(got.size()), 32'd52);
      chk({nome, " sum"}, 32'(soma), 32'd340);
      for (int v = 1; v <= 9; v++) chk({nome, " rank"}, 32'(cnt[v]), 32'd4);
      chk({nome, " tens"}, 32'(cnt[10]), 32'd16);
   endtask

   task automatic schedule(output int seq[$]);
      seq.delete();
      for (int k = 0; k < 30; k++) begin
         pedido = (k % 3 != 1);
         @(negedge clock);
         if (carta_valida === 1'b1) seq.push_back(int'(carta));
      end
      pedido = 1'b0;
      @(negedge clock);
      if (carta_valida === 1'b1) seq.push_back(int'(carta));
   endtask

   initial begin
      logic [3:0] prev;
      resetar    = 1'b1;
      embaralhar = 1'b0;
      pedido     = 1'b0;

      // Model pins: first LFSR steps from the seed, computed by hand
      chk("lfsr step1", 32'(lfsr_prox(8'hA5)), 32'h4A);
      chk("lfsr step2", 32'(lfsr_prox(8'h4A)), 32'h95);

      repeat (2) @(negedge clock);
      resetar = 1'b0;

      // Initial shuffle
      wait_pronto("reset");
      chk("full restantes", 32'(cartas_restantes), 32'd52);
      chk("full vazio", 32'(baralho_vazio), 32'd0);

      // Deal the whole deck one request at a time
      got.delete();
      for (int k = 0; k < N; k++) pede_uma();
      check_multiset("deal1");
      chk("empty vazio", 32'(baralho_vazio), 32'd1);
      chk("empty restantes", 32'(cartas_restantes), 32'd0);

      // 53rd request is ignored
      prev = carta;
      pedido = 1'b1;
      @(negedge clock);
      pedido = 1'b0;
      chk("extra pulse", 32'(carta_valida), 32'd0);
      chk("extra carta", 32'(carta), 32'(prev));
      chk("extra vazio", 32'(baralho_vazio), 32'd1);
      $display("extra request: carta=%0d valida=%0d", carta, carta_valida);

      // Reshuffle, then a 3-cycle burst
      embaralhar = 1'b1;
      @(negedge clock);
      embaralhar = 1'b0;
      chk("reshuffle pronto drop", 32'(pronto), 32'd0);
      wait_pronto("reshuffle");
      got.delete();
      pedido = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         if (k == 2) pedido = 1'b0;
         chk("burst pulse", 32'(carta_valida), 32'd1);
         got.push_back(int'(carta));
         $display("burst %0d: carta=%0d", k, carta);
      end
      chk("burst restantes", 32'(cartas_restantes), 32'd49);
      for (int k = 0; k < 7; k++) pede_uma();
      chk("ten dealt", 32'(cartas_restantes), 32'd42);

      // Reshuffle and request together: command wins
      embaralhar = 1'b1;
      pedido     = 1'b1;
      @(negedge clock);
      embaralhar = 1'b0;
      pedido     = 1'b0;
      chk("collide pulse", 32'(carta_valida), 32'd0);
      chk("collide pronto", 32'(pronto), 32'd0);
      $display("collide: valida=%0d pronto=%0d", carta_valida, pronto);
      wait_pronto("collide");
      chk("collide restantes", 32'(cartas_restantes), 32'd52);
      got.delete();
      for (int k = 0; k < N; k++) pede_uma();
      check_multiset("deal2");

      // Reset during the first ESCREVE_I of a fresh shuffle
      do_reset();
      #1;
      repeat (m_first_esc) @(negedge clock);
      resetar = 1'b1;
      @(negedge clock);
      resetar = 1'b0;
      chk("midreset carta", 32'(carta), 32'd0);
      chk("midreset valida", 32'(carta_valida), 32'd0);
      chk("midreset pronto", 32'(pronto), 32'd0);
      chk("midreset restantes", 32'(cartas_restantes), 32'd0);
      $display("mid-shuffle reset applied after %0d cycles", m_first_esc);

      // Seed determinism across two runs, with a reset from a dealt state
      wait_pronto("det1");
      schedule(seq1);
      resetar = 1'b1;
      @(negedge clock);
      chk("rst carta", 32'(carta), 32'd0);
      chk("rst pronto", 32'(pronto), 32'd0);
      chk("rst vazio", 32'(baralho_vazio), 32'd0);
      chk("rst restantes", 32'(cartas_restantes), 32'd0);
      resetar = 1'b0;
      wait_pronto("det2");
      schedule(seq2);
      chk("det length", 32'(seq2.size()), 32'd20);
      chk("det length match", 32'(seq2.size()), 32'(seq1.size()));
      for (int k = 0; k < seq1.size() && k < seq2.size(); k++) begin
         chk("det card", 32'(seq2[k]), 32'(seq1[k]));
      end
      $display("determinism: run1=%0d cards run2=%0d cards", seq1.size(), seq2.size());

      repeat (2) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
